// File: rtl/cr_huf_comp_is_long_rdr_pkg.sv
// Shared types for the Huffman compressor long-symbol side channel:
// eob codes, reader FSM states and the block summary record.
package cr_huf_compPKG;

  localparam int CNT_W_DEF = 16;
  localparam int SUM_W_DEF = 24;

  typedef enum logic [1:0] {
    PIPE_EOB_NONE  = 2'd0,
    PIPE_EOB_END   = 2'd1,
    PIPE_EOB_FLUSH = 2'd2,
    PIPE_EOB_ABORT = 2'd3
  } e_pipe_eob;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } e_rdr_state;

  // Summary record at the default counter/accumulator widths.
  typedef struct packed {
    logic [3:0]           seq_id;
    e_pipe_eob            eob;
    logic [CNT_W_DEF-1:0] sym_cnt;
    logic [SUM_W_DEF-1:0] len_sum;
    logic                 err;
  } s_is_long_blk_summary;

endpackage

// File: rtl/cr_huf_comp_is_long_rdr_if.sv
// Side-channel FIFO head (show-ahead) and block summary valid/ready bundles.
interface sc_is_long_if;
  logic       sc_is_long_vld;
  logic [2:0] sc_is_long_cnt;
  logic [7:0] sc_is_long_long;
  logic [3:0] sc_is_long_seq_id;
  logic [1:0] sc_is_long_eob;
  logic       is_sc_long_rd;

  modport master (
    output sc_is_long_vld, sc_is_long_cnt, sc_is_long_long,
           sc_is_long_seq_id, sc_is_long_eob,
    input  is_sc_long_rd
  );
  modport slave (
    input  sc_is_long_vld, sc_is_long_cnt, sc_is_long_long,
           sc_is_long_seq_id, sc_is_long_eob,
    output is_sc_long_rd
  );
endinterface

interface blk_summary_if
  import cr_huf_compPKG::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int SUM_W = SUM_W_DEF
);
  logic             blk_vld;
  logic             blk_rdy;
  logic [3:0]       blk_seq_id;
  logic [1:0]       blk_eob;
  logic [CNT_W-1:0] blk_sym_cnt;
  logic [SUM_W-1:0] blk_len_sum;
  logic             blk_err;

  modport master (
    output blk_vld, blk_seq_id, blk_eob, blk_sym_cnt, blk_len_sum, blk_err,
    input  blk_rdy
  );
  modport slave (
    input  blk_vld, blk_seq_id, blk_eob, blk_sym_cnt, blk_len_sum, blk_err,
    output blk_rdy
  );
endinterface

// File: rtl/cr_huf_comp_sat_acc.sv
// Saturating add-or-load accumulator; acc_next is the value the register
// takes at the next edge, so callers can capture a total that includes this cycle.
module cr_huf_comp_sat_acc #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             add,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] acc_next
);
  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH:0]   sum_wide;

  always_comb begin
    sum_wide = {1'b0, acc_reg} + {1'b0, din};
    acc_next = acc_reg;
    if (load) begin
      acc_next = din;
    end else if (add) begin
      acc_next = sum_wide[WIDTH] ? '1 : sum_wide[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg <= '0;
    end else begin
      acc_reg <= acc_next;
    end
  end
endmodule

// File: rtl/cr_huf_comp_is_long_rdr.sv
// Long-symbol side-channel reader: pops FIFO entries, accumulates per-block
// symbol count and long-length sum, emits one summary per block.
module cr_huf_comp_is_long_rdr
  import cr_huf_compPKG::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int SUM_W = SUM_W_DEF
) (
  input  logic          clk,
  input  logic          rst,
  sc_is_long_if.slave   sc,
  blk_summary_if.master blk
);
  e_rdr_state       state_reg, state_next;
  logic             pop, first, eob_hit;
  logic             cnt_bit, cnt_bad, seq_diff;
  logic [3:0]       cur_seq_reg, cur_seq_next;
  logic             err_reg, err_next;
  logic [CNT_W-1:0] cnt_din, cnt_next;
  logic [SUM_W-1:0] len_din, len_next;
  logic [3:0]       blk_seq_id_reg;
  logic [1:0]       blk_eob_reg;
  logic [CNT_W-1:0] blk_sym_cnt_reg;
  logic [SUM_W-1:0] blk_len_sum_reg;
  logic             blk_err_reg;

  // A held summary blocks the FIFO until downstream takes it.
  assign pop      = sc.sc_is_long_vld && !rst && (state_reg != ST_HOLD || blk.blk_rdy);
  assign first    = pop && (state_reg != ST_ACCUM);
  assign eob_hit  = pop && (sc.sc_is_long_eob != PIPE_EOB_NONE);
  assign cnt_bit  = sc.sc_is_long_cnt[0];
  assign cnt_bad  = |sc.sc_is_long_cnt[2:1];
  assign seq_diff = sc.sc_is_long_seq_id != cur_seq_reg;

  assign cnt_din      = CNT_W'(cnt_bit);
  assign len_din      = cnt_bit ? SUM_W'(sc.sc_is_long_long) : '0;
  assign cur_seq_next = first ? sc.sc_is_long_seq_id : cur_seq_reg;
  assign err_next     = cnt_bad | (first ? 1'b0 : (err_reg | seq_diff));

  cr_huf_comp_sat_acc #(.WIDTH(CNT_W)) u_sym_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (first),
    .add      (pop && !first),
    .din      (cnt_din),
    .acc_next (cnt_next)
  );

  cr_huf_comp_sat_acc #(.WIDTH(SUM_W)) u_len_sum (
    .clk      (clk),
    .rst      (rst),
    .load     (first),
    .add      (pop && !first),
    .din      (len_din),
    .acc_next (len_next)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (pop) state_next = eob_hit ? ST_HOLD : ST_ACCUM;
      end
      ST_ACCUM: begin
        if (eob_hit) state_next = ST_HOLD;
      end
      ST_HOLD: begin
        if (blk.blk_rdy) begin
          if (pop) state_next = eob_hit ? ST_HOLD : ST_ACCUM;
          else     state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      cur_seq_reg <= '0;
      err_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (pop) begin
        cur_seq_reg <= cur_seq_next;
        err_reg     <= err_next;
      end
    end
  end

  // Summary captures totals including the terminating entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_seq_id_reg  <= '0;
      blk_eob_reg     <= '0;
      blk_sym_cnt_reg <= '0;
      blk_len_sum_reg <= '0;
      blk_err_reg     <= 1'b0;
    end else if (eob_hit) begin
      blk_seq_id_reg  <= cur_seq_next;
      blk_eob_reg     <= sc.sc_is_long_eob;
      blk_sym_cnt_reg <= cnt_next;
      blk_len_sum_reg <= len_next;
      blk_err_reg     <= err_next;
    end
  end

  assign sc.is_sc_long_rd = pop;
  assign blk.blk_vld      = (state_reg == ST_HOLD);
  assign blk.blk_seq_id   = blk_seq_id_reg;
  assign blk.blk_eob      = blk_eob_reg;
  assign blk.blk_sym_cnt  = blk_sym_cnt_reg;
  assign blk.blk_len_sum  = blk_len_sum_reg;
  assign blk.blk_err      = blk_err_reg;
endmodule

// File: tb/tb_cr_huf_comp_is_long_rdr.sv
// Bench for the long-symbol reader: default-width and CNT_W=4 instances share
// one stimulus stream and one block-level reference model.
module tb_cr_huf_comp_is_long_rdr;
  import cr_huf_compPKG::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vld = 1'b0;
  logic [2:0] cnt = '0;
  logic [7:0] lng = '0;
  logic [3:0] seq = '0;
  logic [1:0] eob = '0;
  logic       rdy = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  bit run_chk = 1'b0;

  always #5 clk = ~clk;

  sc_is_long_if  sc_if ();
  sc_is_long_if  sc_if4 ();
  blk_summary_if blk_if ();
  blk_summary_if #(.CNT_W(4)) blk_if4 ();

  assign sc_if.sc_is_long_vld     = vld;
  assign sc_if.sc_is_long_cnt     = cnt;
  assign sc_if.sc_is_long_long    = lng;
  assign sc_if.sc_is_long_seq_id  = seq;
  assign sc_if.sc_is_long_eob     = eob;
  assign sc_if4.sc_is_long_vld    = vld;
  assign sc_if4.sc_is_long_cnt    = cnt;
  assign sc_if4.sc_is_long_long   = lng;
  assign sc_if4.sc_is_long_seq_id = seq;
  assign sc_if4.sc_is_long_eob    = eob;
  assign blk_if.blk_rdy           = rdy;
  assign blk_if4.blk_rdy          = rdy;

  cr_huf_comp_is_long_rdr dut (
    .clk (clk),
    .rst (rst),
    .sc  (sc_if),
    .blk (blk_if)
  );

  cr_huf_comp_is_long_rdr #(.CNT_W(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .sc  (sc_if4),
    .blk (blk_if4)
  );

  // Reference model: the open block is a list of popped entries; a summary is
  // computed from the whole list when the terminating entry arrives.
  typedef struct {
    logic [2:0] c;
    logic [7:0] l;
    logic [3:0] s;
  } ent_t;

  ent_t                 blk_q[$];
  bit                   m_pend = 1'b0;
  s_is_long_blk_summary m_rec;
  int                   m_raw_cnt = 0;

  function automatic logic exp_rd();
    return !rst && vld && (!m_pend || rdy);
  endfunction

  task automatic model_clear();
    blk_q.delete();
    m_pend = 1'b0;
  endtask

  task automatic model_step();
    bit   popped;
    int   c;
    longint s;
    bit   e;
    ent_t ent;
    if (rst) begin
      model_clear();
      return;
    end
    popped = exp_rd();
    if (m_pend && rdy) m_pend = 1'b0;
    if (popped) begin
      ent.c = cnt; ent.l = lng; ent.s = seq;
      blk_q.push_back(ent);
      if (eob != 2'd0) begin
        c = 0; s = 0; e = 1'b0;
        foreach (blk_q[i]) begin
          if (blk_q[i].c[0]) begin
            c++;
            s += blk_q[i].l;
          end
          if (blk_q[i].c > 3'd1) e = 1'b1;
          if (blk_q[i].s != blk_q[0].s) e = 1'b1;
        end
        m_raw_cnt     = c;
        m_rec.seq_id  = blk_q[0].s;
        m_rec.eob     = e_pipe_eob'(eob);
        m_rec.sym_cnt = (c > 65535) ? 16'hFFFF : 16'(c);
        m_rec.len_sum = (s > 64'hFFFFFF) ? 24'hFFFFFF : 24'(s);
        m_rec.err     = e;
        m_pend        = 1'b1;
        blk_q.delete();
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison on the inactive edge.
  always @(negedge clk) begin
    if (run_chk) begin
      chk("rd",  32'(sc_if.is_sc_long_rd),  32'(exp_rd()));
      chk("rd4", 32'(sc_if4.is_sc_long_rd), 32'(exp_rd()));
      chk("vld",  32'(blk_if.blk_vld),  32'(m_pend));
      chk("vld4", 32'(blk_if4.blk_vld), 32'(m_pend));
      if (m_pend) begin
        chk("seq_id", 32'(blk_if.blk_seq_id),  32'(m_rec.seq_id));
        chk("eob",    32'(blk_if.blk_eob),     32'(m_rec.eob));
        chk("sym",    32'(blk_if.blk_sym_cnt), 32'(m_rec.sym_cnt));
        chk("len",    32'(blk_if.blk_len_sum), 32'(m_rec.len_sum));
        chk("err",    32'(blk_if.blk_err),     32'(m_rec.err));
        chk("sym4",   32'(blk_if4.blk_sym_cnt), 32'((m_raw_cnt > 15) ? 15 : m_raw_cnt));
        chk("len4",   32'(blk_if4.blk_len_sum), 32'(m_rec.len_sum));
        chk("err4",   32'(blk_if4.blk_err),     32'(m_rec.err));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] c, input logic [7:0] l,
                       input logic [3:0] s, input logic [1:0] e, input logic r);
    vld = v; cnt = c; lng = l; seq = s; eob = e; rdy = r;
    tick();
  endtask

  initial begin
    logic [3:0] rseq;
    // Reset with a non-empty FIFO: nothing may be popped.
    rst = 1'b1; vld = 1'b1; cnt = 3'd1; lng = 8'd77;
    tick();
    run_chk = 1'b1;
    tick();
    chk("rst_rd",  32'(sc_if.is_sc_long_rd), 32'd0);
    chk("rst_vld", 32'(blk_if.blk_vld),      32'd0);
    chk("rst_sym", 32'(blk_if.blk_sym_cnt),  32'd0);
    chk("rst_len", 32'(blk_if.blk_len_sum),  32'd0);
    chk("rst_err", 32'(blk_if.blk_err),      32'd0);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 1);

    // Three-entry block.
    drive(1, 1, 10, 3, 0, 1);
    drive(1, 1, 20, 3, 0, 1);
    drive(1, 1, 30, 3, 1, 1);
    chk("t1_vld", 32'(blk_if.blk_vld),     32'd1);
    chk("t1_sym", 32'(blk_if.blk_sym_cnt), 32'd3);
    chk("t1_len", 32'(blk_if.blk_len_sum), 32'd60);
    chk("t1_seq", 32'(blk_if.blk_seq_id),  32'd3);
    chk("t1_eob", 32'(blk_if.blk_eob),     32'd1);
    chk("t1_err", 32'(blk_if.blk_err),     32'd0);
    chk("t1_model_len", 32'(m_rec.len_sum), 32'd60);
    drive(0, 0, 0, 0, 0, 1);

    // Single-entry block held under backpressure.
    drive(1, 1, 255, 6, 1, 0);
    repeat (5) drive(1, 1, 7, 5, 1, 0);
    chk("t2_hold_len", 32'(blk_if.blk_len_sum), 32'd255);
    chk("t2_hold_rd",  32'(sc_if.is_sc_long_rd), 32'd0);
    drive(1, 1, 7, 5, 1, 1);
    chk("t2_next_len", 32'(blk_if.blk_len_sum), 32'd7);
    drive(0, 0, 0, 0, 0, 1);

    // Back-to-back single-entry blocks.
    for (int i = 0; i < 6; i++) drive(1, 1, 8'(i + 1), 4'(i), 1, 1);
    drive(0, 0, 0, 0, 0, 1);

    // cnt=0 entry in the middle.
    drive(1, 1, 5, 7, 0, 1);
    drive(1, 0, 99, 7, 0, 1);
    drive(1, 1, 5, 7, 1, 1);
    chk("t4_sym", 32'(blk_if.blk_sym_cnt), 32'd2);
    chk("t4_len", 32'(blk_if.blk_len_sum), 32'd10);
    drive(0, 0, 0, 0, 0, 1);

    // Sequence id change mid-block, then an illegal cnt.
    drive(1, 1, 1, 2, 0, 1);
    drive(1, 1, 1, 4, 1, 1);
    chk("t5_err", 32'(blk_if.blk_err),    32'd1);
    chk("t5_seq", 32'(blk_if.blk_seq_id), 32'd2);
    drive(1, 2, 40, 8, 1, 1);
    chk("t5_cnt2_err", 32'(blk_if.blk_err), 32'd1);
    chk("t5_cnt2_sym", 32'(blk_if.blk_sym_cnt), 32'd0);
    drive(0, 0, 0, 0, 0, 1);

    // Saturation of the narrow counter.
    repeat (20) drive(1, 1, 1, 1, 0, 1);
    drive(1, 1, 1, 1, 1, 1);
    chk("t6_sym4", 32'(blk_if4.blk_sym_cnt), 32'd15);
    chk("t6_sym",  32'(blk_if.blk_sym_cnt),  32'd21);
    drive(0, 0, 0, 0, 0, 1);

    // Reset in the middle of an open block.
    repeat (3) drive(1, 1, 50, 9, 0, 1);
    rst = 1'b1; vld = 1'b0;
    model_clear();
    #1;
    chk("t7_rst_vld", 32'(blk_if.blk_vld), 32'd0);
    tick();
    rst = 1'b0;
    drive(1, 1, 3, 9, 0, 1);
    drive(1, 1, 4, 9, 1, 1);
    chk("t7_sym", 32'(blk_if.blk_sym_cnt), 32'd2);
    chk("t7_len", 32'(blk_if.blk_len_sum), 32'd7);
    drive(0, 0, 0, 0, 0, 1);

    // Randomized traffic.
    rseq = 4'd0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1; vld = 1'b0;
        model_clear();
        tick();
        rst = 1'b0;
      end
      if ($urandom_range(0, 9) == 0) rseq = 4'($urandom_range(0, 15));
      drive(($urandom_range(0, 3) != 0),
            ($urandom_range(0, 15) == 0) ? 3'($urandom_range(2, 7)) : 3'($urandom_range(0, 1)),
            8'($urandom_range(0, 255)),
            ($urandom_range(0, 19) == 0) ? 4'($urandom_range(0, 15)) : rseq,
            ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'd0,
            ($urandom_range(0, 9) < 7));
    end
    repeat (3) drive(0, 0, 0, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
